// File: rtl/rtc_regfile_pkg.sv
// Shared types and constants for the RTC register file: FSM states, register
// indices, read masks, status bit positions and the staging reset word.
package rtc_regfile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET      = 3'd1,
        ST_SET_WAIT = 3'd2,
        ST_GET      = 3'd3,
        ST_GET_WAIT = 3'd4,
        ST_LATCH    = 3'd5
    } state_t;

    localparam logic [2:0] REG_SEC     = 3'd0;
    localparam logic [2:0] REG_MIN     = 3'd1;
    localparam logic [2:0] REG_HOUR    = 3'd2;
    localparam logic [2:0] REG_DAY     = 3'd3;
    localparam logic [2:0] REG_WEEKDAY = 3'd4;
    localparam logic [2:0] REG_MONTH   = 3'd5;
    localparam logic [2:0] REG_YEAR    = 3'd6;
    localparam logic [2:0] REG_STATUS  = 3'd7;

    // Per-field read masks, laid out like the 56-bit time word (sec in the top byte).
    localparam logic [55:0] READ_MASK = 56'h7F_7F_3F_3F_07_1F_FF;

    // Commit limits, same layout; year accepts any valid BCD.
    localparam logic [55:0] FIELD_MAX = 56'h59_59_23_31_06_12_99;
    // Bit g refers to byte g counted from the LSB: day (3) and month (1) start at 01.
    localparam logic [6:0]  FIELD_MIN_ONE = 7'b000_1010;

    localparam int STAT_VALID = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_ERR   = 2;
    localparam int STAT_VL    = 7;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_REFRESH = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam logic [55:0] RTC_IN_RESET = 56'h00_00_00_01_00_01_00;

    // Byte of a time word selected by register index 0..6 (0 = sec, MSB first).
    function automatic logic [7:0] field_of(input logic [55:0] w, input logic [2:0] idx);
        int sh;
        if (idx > REG_YEAR) return 8'h00;
        sh = 8 * (6 - int'(idx));
        return w[sh +: 8];
    endfunction

endpackage

// File: rtl/rtc_regfile_bcd_range_check.sv
// Checks one staged byte: both nibbles decimal, not above max, optionally non-zero.
module bcd_range_check (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       min_one,
    output logic       ok
);

    // Valid BCD compares correctly as plain binary, so the range test is a direct compare.
    assign ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                (value <= max) && !(min_one && (value == 8'h00));

endmodule

// File: rtl/rtc_regfile.sv
// CPU register file in front of the PCF8563 I2C engine: stages time writes,
// sequences commit/refresh handshakes and keeps a masked snapshot for reads.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for commit, refresh-now or pending timer refresh
// SET       | rtc_set held high for SET_HOLD cycles
// SET_WAIT  | engine write settling, SETTLE_CYCLES
// GET       | rtc_get pulsed for one cycle
// GET_WAIT  | engine read settling, SETTLE_CYCLES
// LATCH     | snapshot <= rtc, valid <= 1, refresh timer restarted
module rtc_regfile
    import rtc_regfile_pkg::*;
#(
    parameter int REFRESH_CYCLES = 28_000_000,
    parameter int SETTLE_CYCLES  = 65536,
    parameter int SET_HOLD       = 4
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    input  logic [55:0] rtc,
    output logic [55:0] rtc_in,
    output logic        rtc_set,
    output logic        rtc_get,
    output logic        busy,
    output logic        valid
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SET_HOLD) ? SETTLE_CYCLES : SET_HOLD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TW      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CW-1:0] HOLD_LOAD   = CW'(SET_HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LOAD    = TW'(REFRESH_CYCLES - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [TW-1:0]  tmr;
    logic           refresh_pending;
    logic           clr_pending;
    logic [55:0]    snapshot;
    logic           err;
    logic [6:0]     field_ok;
    logic           fields_ok;
    logic           wr_ctrl, commit_req, refresh_req, commit_bad;
    logic [7:0]     status;

    assign wr_ctrl     = cpu_wr && (cpu_addr == REG_STATUS);
    assign commit_req  = wr_ctrl && cpu_din[CTRL_COMMIT];
    assign refresh_req = wr_ctrl && cpu_din[CTRL_REFRESH];
    assign fields_ok   = &field_ok;
    assign commit_bad  = (state == ST_IDLE) && commit_req && !fields_ok;

    assign busy    = (state != ST_IDLE);
    assign rtc_set = (state == ST_SET);
    assign rtc_get = (state == ST_GET);

    for (genvar g = 0; g < 7; g++) begin : g_chk
        bcd_range_check u_chk (
            .value   (rtc_in[8*g +: 8]),
            .max     (FIELD_MAX[8*g +: 8]),
            .min_one (FIELD_MIN_ONE[g]),
            .ok      (field_ok[g])
        );
    end

    // State and settle/hold counter registers.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a commit attempt (valid or not) takes the cycle over any refresh.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != '0) ? cnt - CW'(1) : cnt;
        clr_pending = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    if (fields_ok) begin
                        state_nxt = ST_SET;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end else if (refresh_pending || refresh_req) begin
                    state_nxt   = ST_GET;
                    clr_pending = 1'b1;
                end
            end
            ST_SET: begin
                if (cnt == '0) begin
                    state_nxt = ST_SET_WAIT;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            ST_SET_WAIT: begin
                if (cnt == '0) state_nxt = ST_GET;
            end
            ST_GET: begin
                state_nxt = ST_GET_WAIT;
                cnt_nxt   = SETTLE_LOAD;
            end
            ST_GET_WAIT: begin
                if (cnt == '0) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Free-running refresh timer; expiry is remembered until IDLE can service it.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            tmr             <= TMR_LOAD;
            refresh_pending <= 1'b1;
        end else begin
            if (state == ST_LATCH || tmr == '0) tmr <= TMR_LOAD;
            else                                tmr <= tmr - TW'(1);
            if (clr_pending)                                refresh_pending <= 1'b0;
            else if (tmr == '0 && state != ST_LATCH)        refresh_pending <= 1'b1;
        end
    end

    // Staging word writes, frozen while the engine may be using it.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            rtc_in <= RTC_IN_RESET;
        end else if (cpu_wr && !busy) begin
            for (int f = 0; f < 7; f++) begin
                if (cpu_addr == 3'(f)) rtc_in[8*(6-f) +: 8] <= cpu_din;
            end
        end
    end

    // Snapshot, valid and error flag.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == ST_LATCH) begin
                snapshot <= rtc;
                valid    <= 1'b1;
            end
            if (commit_bad)                          err <= 1'b1;
            else if (wr_ctrl && cpu_din[CTRL_CLR_ERR]) err <= 1'b0;
        end
    end

    // Status byte assembled from current (pre-edge) flags.
    always_comb begin
        status             = 8'h00;
        status[STAT_VL]    = snapshot[55];
        status[STAT_ERR]   = err;
        status[STAT_BUSY]  = busy;
        status[STAT_VALID] = valid;
    end

    // Registered read port.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cpu_dout <= 8'h00;
        end else if (cpu_rd) begin
            if (cpu_addr == REG_STATUS) cpu_dout <= status;
            else cpu_dout <= field_of(snapshot, cpu_addr) & field_of(READ_MASK, cpu_addr);
        end
    end

endmodule

// File: doc/rtc_regfile.md
# rtc_regfile

CPU-facing register file for the board RTC, sitting directly upstream of the PCF8563 I2C engine: it stages CPU writes into the 56-bit `rtc_in` word and raises `rtc_set`. It also raises `rtc_get` periodically and latches the engine's 56-bit `rtc` BCD word into a masked snapshot for CPU reads. All fields are BCD, ordered {sec,min,hour,day,weekday,month,year}, MSB first.

## Interface
Parameters:
- REFRESH_CYCLES, 28_000_000 — mclk cycles between automatic refreshes (1 s at 28 MHz)
- SETTLE_CYCLES, 65536 — mclk cycles allowed for an engine transaction to complete before sampling
- SET_HOLD, 4 — mclk cycles `rtc_set` is held high

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  3  register index 0–7
- cpu_din  in  8  write data
- cpu_wr  in  1  write strobe, one cycle
- cpu_rd  in  1  read strobe, one cycle
- cpu_dout  out  8  registered read data
- rtc  in  56  BCD time word from the I2C engine
- rtc_in  out  56  staged BCD time word to the engine
- rtc_set  out  1  commit request to the engine
- rtc_get  out  1  refresh request to the engine
- busy  out  1  FSM not in IDLE
- valid  out  1  snapshot holds at least one completed refresh

## Operation
- Register map for reads (0–6 return snapshot & mask):
  - 0 sec & 7F
  - 1 min & 7F
  - 2 hour & 3F
  - 3 day & 3F
  - 4 weekday & 07
  - 5 month & 1F
  - 6 year & FF
  - 7 status {VL, 4'b0, err, busy, valid}. VL is snapshot sec bit7.
- Writes to 0–6 load staging field N of `rtc_in`, unmasked. They are ignored while busy, because `rtc_in` must be stable during the engine write.
- Write to 7:
  - bit0 = commit.
  - bit1 = refresh now.
  - bit2 = 1 clears err.
  - When bit0 and bit1 are both set, commit wins; its sequence already ends in a refresh.
- Commit validation: every staged field must be valid BCD (both nibbles ≤9) and within range:
  - sec/min ≤59
  - hour ≤23
  - day 01–31
  - weekday ≤6
  - month 01–12
  - year any BCD
  - Any failure: err=1, no `rtc_set`, FSM stays IDLE.
- Commit or refresh while busy is ignored (not queued).
- The refresh timer counts mclk in every state. On expiry it sets refresh_pending, which is serviced on the next IDLE.
- FSM states:
  - IDLE: commit (valid) → SET; refresh_pending or refresh-now → GET, clearing pending.
  - SET: `rtc_set`=1 for SET_HOLD cycles → SET_WAIT.
  - SET_WAIT: SETTLE_CYCLES → GET.
  - GET: `rtc_get`=1 for 1 cycle → GET_WAIT.
  - GET_WAIT: SETTLE_CYCLES → LATCH.
  - LATCH: snapshot←`rtc`, valid←1, restart refresh timer → IDLE.
- Reset values:
  - `rtc_in` = {00,00,00,01,00,01,00}
  - `rtc_set`=0, `rtc_get`=0, cpu_dout=00, busy=0, valid=0, err=0
  - snapshot=0, FSM=IDLE
  - refresh_pending=1, so the first refresh starts on the first cycle after reset release.
- Reset mid-sequence: all of the above values are applied immediately; `rtc_set`/`rtc_get` drop asynchronously.

## Timing
- cpu_dout updates on the mclk edge where cpu_rd=1; data is valid the following cycle. It holds its value otherwise.
- Read of 0–6 during LATCH returns the pre-latch snapshot. Status read in the same cycle as a commit write returns the pre-write status.
- busy rises the cycle after a commit or refresh is accepted. It falls on the cycle FSM enters IDLE from LATCH.
- Commit latency to new snapshot = SET_HOLD + SETTLE_CYCLES + 1 + SETTLE_CYCLES + 1 cycles. Refresh-only latency = 1 + SETTLE_CYCLES + 1.
- Timer uses a ceil(log2(REFRESH_CYCLES))-bit down-counter and wraps from 0 to REFRESH_CYCLES-1. Settle/hold share one counter sized for max(SETTLE_CYCLES, SET_HOLD).

## Structure
- Package `rtc_regfile_pkg`:
  - FSM state enum
  - register index constants (REG_SEC..REG_STATUS)
  - read mask constants
  - status bit positions
  - reset staging word
- Sub-module `bcd_range_check` (8-bit value, max, min_one flag → ok), instantiated seven times for commit validation.

## Test plan
All scenarios use REFRESH_CYCLES=200, SETTLE_CYCLES=20, SET_HOLD=4.
- Reset release with `rtc`=00_59_23_03_06_01_10 → `rtc_get` pulses on cycle 1; after 22 cycles valid=1, reg2 reads 23, reg6 reads 10.
- `rtc` sec byte = 0x85 → reg0 reads 05, status bit7=1.
- Write 0x30,0x15,0x12,0x24,0x02,0x08,0x25 to regs 0–6, then 0x01 to reg7 → `rtc_in`=30_15_12_24_02_08_25, `rtc_set` high exactly 4 cycles, then `rtc_get` after 20, busy for 46 cycles.
- Stage month=0x13 and commit → err=1 (status=0x05 with valid), no `rtc_set`; write 0x04 to reg7 → err=0.
- During SET_WAIT, write reg0=0x11 and reg7=0x02 → `rtc_in` unchanged, no extra `rtc_get`; timer expiry while busy yields one refresh immediately after return to IDLE.
- Assert reset mid-SET → `rtc_set` drops without a clock edge, valid=0; a new refresh starts after release.
